// File: rtl/bit_timing.sv
// Bit timing engine for a CAN-FD style controller.
//
// Each bit is split into SYNC (1 tq), TSEG1 (tseg1+1 tq) and TSEG2 (tseg2+1 tq),
// where one time quantum is brp+1 clocks. At entry to SYNC the block latches
// fdPhase and the matching nominal or data configuration, and holds them for the
// whole bit. A falling edge on rx during TSEG1/TSEG2 (with hardSyncEn) restarts
// TSEG1.
//
// Ports:
//   clock          system clock, rising-edge active
//   resetN         asynchronous active-low reset
//   enable         1 = run, 0 = return to idle on the next clock
//   rx             bus receive level (synchronous to clock)
//   hardSyncEn     allow a 1->0 rx edge to hard-sync the bit
//   fdPhase        1 = next bit uses the data-phase configuration
//   brpNom/tseg1Nom/tseg2Nom     nominal prescaler and segments (value - 1)
//   brpData/tseg1Data/tseg2Data  data-phase prescaler and segments (value - 1)
//   samplePoint    registered pulse, first clock of TSEG2 in a nominal bit
//   samplePointFD  registered pulse, first clock of TSEG2 in a data-phase bit
//   bitStart       registered pulse, first clock of SYNC
module bit_timing #(
  parameter int unsigned NOM_W = 8,
  parameter int unsigned DAT_W = 5
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             enable,
  input  logic             rx,
  input  logic             hardSyncEn,
  input  logic             fdPhase,
  input  logic [NOM_W-1:0] brpNom,
  input  logic [NOM_W-1:0] tseg1Nom,
  input  logic [NOM_W-1:0] tseg2Nom,
  input  logic [DAT_W-1:0] brpData,
  input  logic [DAT_W-1:0] tseg1Data,
  input  logic [DAT_W-1:0] tseg2Data,
  output logic             samplePoint,
  output logic             samplePointFD,
  output logic             bitStart
);

  // Latched configuration is held at the wider of the two field widths.
  localparam int unsigned CfgW = (NOM_W > DAT_W) ? NOM_W : DAT_W;

  typedef enum logic [1:0] {StIdle, StSync, StTseg1, StTseg2} state_e;

  state_e            state_q;
  logic [CfgW-1:0]   presc_q;
  logic [CfgW-1:0]   seg_q;
  logic [CfgW-1:0]   brp_q;
  logic [CfgW-1:0]   tseg1_q;
  logic [CfgW-1:0]   tseg2_q;
  logic              fd_q;
  logic              prev_rx_q;

  logic            tq_end;
  logic            rx_fall;
  logic            hard_sync;
  logic [CfgW-1:0] sel_brp;
  logic [CfgW-1:0] sel_tseg1;
  logic [CfgW-1:0] sel_tseg2;

  assign tq_end    = (presc_q == brp_q);
  assign rx_fall   = prev_rx_q & ~rx;
  assign hard_sync = hardSyncEn & rx_fall & ((state_q == StTseg1) | (state_q == StTseg2));

  // Configuration captured on the edge that enters SYNC.
  assign sel_brp   = fdPhase ? CfgW'(brpData)   : CfgW'(brpNom);
  assign sel_tseg1 = fdPhase ? CfgW'(tseg1Data) : CfgW'(tseg1Nom);
  assign sel_tseg2 = fdPhase ? CfgW'(tseg2Data) : CfgW'(tseg2Nom);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      seg_q         <= '0;
      brp_q         <= '0;
      tseg1_q       <= '0;
      tseg2_q       <= '0;
      fd_q          <= 1'b0;
      prev_rx_q     <= 1'b1;
      samplePoint   <= 1'b0;
      samplePointFD <= 1'b0;
      bitStart      <= 1'b0;
    end else begin
      prev_rx_q     <= rx;
      samplePoint   <= 1'b0;
      samplePointFD <= 1'b0;
      bitStart      <= 1'b0;

      if (!enable) begin
        state_q <= StIdle;
        presc_q <= '0;
        seg_q   <= '0;
      end else if (hard_sync) begin
        // The tq holding the edge stands in for SYNC; no bitStart, and any
        // sample point due on this edge is dropped.
        state_q <= StTseg1;
        presc_q <= '0;
        seg_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q  <= StSync;
            presc_q  <= '0;
            seg_q    <= '0;
            fd_q     <= fdPhase;
            brp_q    <= sel_brp;
            tseg1_q  <= sel_tseg1;
            tseg2_q  <= sel_tseg2;
            bitStart <= 1'b1;
          end
          StSync: begin
            if (tq_end) begin
              state_q <= StTseg1;
              presc_q <= '0;
              seg_q   <= '0;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          StTseg1: begin
            if (tq_end) begin
              presc_q <= '0;
              if (seg_q == tseg1_q) begin
                state_q       <= StTseg2;
                seg_q         <= '0;
                samplePoint   <= ~fd_q;
                samplePointFD <= fd_q;
              end else begin
                seg_q <= seg_q + 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          StTseg2: begin
            if (tq_end) begin
              presc_q <= '0;
              if (seg_q == tseg2_q) begin
                state_q  <= StSync;
                seg_q    <= '0;
                fd_q     <= fdPhase;
                brp_q    <= sel_brp;
                tseg1_q  <= sel_tseg1;
                tseg2_q  <= sel_tseg2;
                bitStart <= 1'b1;
              end else begin
                seg_q <= seg_q + 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            presc_q <= '0;
            seg_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule
